// File: rtl/led_seq_pkg.sv
// Shared encodings for the LED sequencer: controller state, display mode, chase direction.
// Pure type definitions; no logic, no latency, no flow control.
package led_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  typedef enum logic {
    MODE_CHASE = 1'b0,
    MODE_BLINK = 1'b1
  } mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

endpackage

// File: rtl/debounce_filter.sv
// Single-switch debouncer: output follows raw only after DEBOUNCE_LIMIT consecutive differing clocks.
// Latency DEBOUNCE_LIMIT clocks from a stable raw change; no backpressure.
module debounce_filter #(
  parameter int DEBOUNCE_LIMIT = 250000
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Raw,
  output logic o_Level
);

  localparam int CW = (DEBOUNCE_LIMIT > 1) ? $clog2(DEBOUNCE_LIMIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_LIMIT - 1);

  logic [CW-1:0] cnt;

  // Any clock where raw agrees with the accepted level restarts the qualification window.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      cnt     <= '0;
      o_Level <= 1'b0;
    end else if (i_Raw == o_Level) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt     <= '0;
      o_Level <= i_Raw;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/led_sequencer.sv
// Four-button LED pattern sequencer (chase / blink-all) with run/pause, direction and speed control.
// Button action lands 2 clocks after debounced release, LEDs 1 clock after that; no backpressure.
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter int STEP_CLKS      = 6250000
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Switch_1,
  input  logic i_Switch_2,
  input  logic i_Switch_3,
  input  logic i_Switch_4,
  output logic o_LED_1,
  output logic o_LED_2,
  output logic o_LED_3,
  output logic o_LED_4,
  output logic o_Running
);

  localparam int CW = $clog2(STEP_CLKS);

  logic [3:0] raw, lvl, lvl_d, rel;

  assign raw = {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1};

  for (genvar g = 0; g < 4; g++) begin : g_db
    debounce_filter #(
      .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
    ) u_db (
      .i_Clk  (i_Clk),
      .i_Rst  (i_Rst),
      .i_Raw  (raw[g]),
      .o_Level(lvl[g])
    );
  end

  // Release pulse is registered so it trails the debounced fall by one clock.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      lvl_d <= '0;
      rel   <= '0;
    end else begin
      lvl_d <= lvl;
      rel   <= lvl_d & ~lvl;
    end
  end

  state_t state_q, state_d;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (rel[0]) begin
      case (state_q)
        ST_IDLE:  state_d = ST_RUN;
        ST_RUN:   state_d = ST_PAUSE;
        ST_PAUSE: state_d = ST_RUN;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  dir_t          dir;
  mode_t         mode;
  logic [1:0]    speed;
  logic [1:0]    pos;
  logic          phase;
  logic [CW-1:0] step_cnt;
  logic [CW:0]   period_last;
  logic          tick, clr;

  // One extra bit so STEP_CLKS itself is representable when it is a power of two.
  assign period_last = ((CW+1)'(STEP_CLKS) >> speed) - (CW+1)'(1);
  assign tick        = (state_q == ST_RUN) && ({1'b0, step_cnt} == period_last);
  assign clr         = rel[2] | rel[3];

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      dir      <= DIR_UP;
      mode     <= MODE_CHASE;
      speed    <= 2'd0;
      pos      <= 2'd0;
      phase    <= 1'b0;
      step_cnt <= '0;
    end else begin
      if (rel[1]) dir   <= (dir == DIR_UP) ? DIR_DOWN : DIR_UP;
      if (rel[2]) speed <= speed + 2'd1;
      if (rel[3]) mode  <= (mode == MODE_CHASE) ? MODE_BLINK : MODE_CHASE;

      if (clr)                    step_cnt <= '0;
      else if (state_q == ST_RUN) step_cnt <= tick ? '0 : step_cnt + CW'(1);

      // A speed/mode change in the tick clock swallows that step.
      if (rel[3])
        pos <= 2'd0;
      else if (tick && !clr && mode == MODE_CHASE)
        pos <= (dir == DIR_UP) ? pos + 2'd1 : pos - 2'd1;

      if (tick && !clr && mode == MODE_BLINK) phase <= ~phase;
    end
  end

  logic [3:0] led_d, led_q;

  always_comb begin
    led_d = '0;
    if (state_q != ST_IDLE) begin
      if (mode == MODE_CHASE) led_d[pos] = 1'b1;
      else                    led_d      = {4{phase}};
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      led_q     <= '0;
      o_Running <= 1'b0;
    end else begin
      led_q     <= led_d;
      o_Running <= (state_q == ST_RUN);
    end
  end

  assign o_LED_1 = led_q[0];
  assign o_LED_2 = led_q[1];
  assign o_LED_3 = led_q[2];
  assign o_LED_4 = led_q[3];

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer with DEBOUNCE_LIMIT=4, STEP_CLKS=16.
// Inputs driven on falling edges, outputs sampled on falling edges.
module tb_led_sequencer;

  localparam int DL = 4;
  localparam int SC = 16;

  logic i_Clk = 1'b0;
  logic i_Rst = 1'b1;
  logic sw1 = 1'b0, sw2 = 1'b0, sw3 = 1'b0, sw4 = 1'b0;
  logic o_LED_1, o_LED_2, o_LED_3, o_LED_4, o_Running;
  logic [3:0] leds;

  int n_vec = 0;
  int n_err = 0;

  assign leds = {o_LED_4, o_LED_3, o_LED_2, o_LED_1};

  always #5 i_Clk = ~i_Clk;

  led_sequencer #(
    .DEBOUNCE_LIMIT(DL),
    .STEP_CLKS     (SC)
  ) dut (
    .i_Clk     (i_Clk),
    .i_Rst     (i_Rst),
    .i_Switch_1(sw1),
    .i_Switch_2(sw2),
    .i_Switch_3(sw3),
    .i_Switch_4(sw4),
    .o_LED_1   (o_LED_1),
    .o_LED_2   (o_LED_2),
    .o_LED_3   (o_LED_3),
    .o_LED_4   (o_LED_4),
    .o_Running (o_Running)
  );

  task automatic set_sw(input int idx, input logic v);
    case (idx)
      1: sw1 = v;
      2: sw2 = v;
      3: sw3 = v;
      default: sw4 = v;
    endcase
  endtask

  // Called on a falling edge; returns on the falling edge 12 clocks later.
  task automatic press_release(input int idx);
    set_sw(idx, 1'b1);
    repeat (6) @(negedge i_Clk);
    set_sw(idx, 1'b0);
    repeat (6) @(negedge i_Clk);
  endtask

  task automatic wait_change(output logic [3:0] v, output int clks, output bit to);
    logic [3:0] s;
    s    = leds;
    clks = 0;
    to   = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge i_Clk);
      clks++;
      if (leds !== s) begin
        to = 1'b0;
        break;
      end
    end
    v = leds;
  endtask

  task automatic wait_running(output bit to);
    to = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge i_Clk);
      if (o_Running === 1'b1) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    i_Rst = 1'b1;
    repeat (3) @(negedge i_Clk);
    n_vec++;
    if (leds !== 4'b0000) begin n_err++; $display("FAIL reset_leds: got %b want %b", leds, 4'b0000); end
    n_vec++;
    if (o_Running !== 1'b0) begin n_err++; $display("FAIL reset_running: got %b want 0", o_Running); end
    i_Rst = 1'b0;
    repeat (5) @(negedge i_Clk);
    n_vec++;
    if (o_Running !== 1'b0 || leds !== 4'b0000) begin
      n_err++; $display("FAIL post_reset_idle: got run=%b leds=%b want run=0 leds=0000", o_Running, leds);
    end
  endtask

  task automatic test_glitch;
    sw1 = 1'b1;
    repeat (3) @(negedge i_Clk);
    sw1 = 1'b0;
    repeat (20) @(negedge i_Clk);
    n_vec++;
    if (o_Running !== 1'b0) begin n_err++; $display("FAIL glitch_running: got %b want 0", o_Running); end
    n_vec++;
    if (leds !== 4'b0000) begin n_err++; $display("FAIL glitch_leds: got %b want 0000", leds); end
  endtask

  task automatic test_start;
    bit to;
    logic [3:0] exp;
    press_release(1);
    wait_running(to);
    n_vec++;
    if (to) begin n_err++; $display("FAIL start_running: got %b want 1 (timeout)", o_Running); end
    n_vec++;
    if (leds !== 4'b0001) begin n_err++; $display("FAIL start_led1: got %b want 0001", leds); end
    repeat (15) @(negedge i_Clk);
    n_vec++;
    if (leds !== 4'b0001) begin n_err++; $display("FAIL step_not_early: got %b want 0001", leds); end
    exp = 4'b0001;
    for (int s = 0; s < 4; s++) begin
      repeat ((s == 0) ? 1 : 16) @(negedge i_Clk);
      exp = {exp[2:0], exp[3]};
      n_vec++;
      if (leds !== exp) begin n_err++; $display("FAIL chase_up_step%0d: got %b want %b", s, leds, exp); end
    end
  endtask

  task automatic test_direction;
    logic [3:0] v;
    int c;
    bit to;
    press_release(2);
    n_vec++;
    if (leds !== 4'b0001) begin n_err++; $display("FAIL dir_hold: got %b want 0001", leds); end
    wait_change(v, c, to);
    n_vec++;
    if (to || v !== 4'b1000 || c != 4) begin
      n_err++; $display("FAIL dir_down_wrap: got %b after %0d clks want 1000 after 4", v, c);
    end
  endtask

  task automatic test_speed;
    logic [3:0] v, prev;
    int c;
    bit to;
    press_release(3);
    press_release(3);
    wait_change(prev, c, to);
    wait_change(v, c, to);
    n_vec++;
    if (to || c != 4) begin n_err++; $display("FAIL speed2_period: got %0d clks want 4", c); end
    n_vec++;
    if (v !== {prev[0], prev[3:1]}) begin
      n_err++; $display("FAIL speed2_dir: got %b want %b", v, {prev[0], prev[3:1]});
    end
    press_release(3);
    press_release(3);
    wait_change(prev, c, to);
    wait_change(v, c, to);
    n_vec++;
    if (to || c != 16) begin n_err++; $display("FAIL speed0_period: got %0d clks want 16", c); end
  endtask

  task automatic test_blink_pause;
    logic [3:0] v, snap;
    int c, bad;
    bit to;
    press_release(4);
    repeat (2) @(negedge i_Clk);
    n_vec++;
    if (leds !== 4'b0000) begin n_err++; $display("FAIL blink_start: got %b want 0000", leds); end
    wait_change(v, c, to);
    n_vec++;
    if (to || v !== 4'b1111 || c != 15) begin
      n_err++; $display("FAIL blink_on: got %b after %0d clks want 1111 after 15", v, c);
    end
    wait_change(v, c, to);
    n_vec++;
    if (to || v !== 4'b0000 || c != 16) begin
      n_err++; $display("FAIL blink_off: got %b after %0d clks want 0000 after 16", v, c);
    end
    press_release(1);
    repeat (2) @(negedge i_Clk);
    snap = leds;
    n_vec++;
    if (o_Running !== 1'b0) begin n_err++; $display("FAIL pause_running: got %b want 0", o_Running); end
    n_vec++;
    if (snap !== 4'b0000 && snap !== 4'b1111) begin
      n_err++; $display("FAIL pause_pattern: got %b want 0000 or 1111", snap);
    end
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge i_Clk);
      if (leds !== snap) bad++;
    end
    n_vec++;
    if (bad != 0) begin n_err++; $display("FAIL pause_frozen: got %0d changed clocks want 0", bad); end
    press_release(1);
    @(negedge i_Clk);
    n_vec++;
    if (o_Running !== 1'b1) begin n_err++; $display("FAIL resume_running: got %b want 1", o_Running); end
    wait_change(v, c, to);
    n_vec++;
    if (to || v !== ~snap) begin n_err++; $display("FAIL resume_toggle: got %b want %b", v, ~snap); end
  endtask

  task automatic test_async_reset;
    bit lit;
    lit = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge i_Clk);
      if (leds === 4'b1111) begin
        lit = 1'b1;
        break;
      end
    end
    n_vec++;
    if (!lit || o_Running !== 1'b1) begin
      n_err++; $display("FAIL pre_reset_lit: got leds=%b run=%b want 1111 run=1", leds, o_Running);
    end
    #2 i_Rst = 1'b1;
    #1;
    n_vec++;
    if (leds !== 4'b0000) begin n_err++; $display("FAIL async_rst_leds: got %b want 0000", leds); end
    n_vec++;
    if (o_Running !== 1'b0) begin n_err++; $display("FAIL async_rst_running: got %b want 0", o_Running); end
    repeat (2) @(negedge i_Clk);
    i_Rst = 1'b0;
    repeat (20) @(negedge i_Clk);
    n_vec++;
    if (o_Running !== 1'b0 || leds !== 4'b0000) begin
      n_err++; $display("FAIL rst_idle: got run=%b leds=%b want run=0 leds=0000", o_Running, leds);
    end
  endtask

  task automatic test_held_through_reset;
    bit to;
    i_Rst = 1'b1;
    sw1   = 1'b1;
    repeat (3) @(negedge i_Clk);
    i_Rst = 1'b0;
    repeat (8) @(negedge i_Clk);
    n_vec++;
    if (o_Running !== 1'b0) begin n_err++; $display("FAIL held_no_release: got %b want 0", o_Running); end
    sw1 = 1'b0;
    repeat (6) @(negedge i_Clk);
    wait_running(to);
    n_vec++;
    if (to) begin n_err++; $display("FAIL held_then_release: got run=%b want 1 (timeout)", o_Running); end
    n_vec++;
    if (leds !== 4'b0001) begin n_err++; $display("FAIL held_led1: got %b want 0001", leds); end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_start();
    test_direction();
    test_speed();
    test_blink_pause();
    test_async_reset();
    test_held_through_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000 want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
